// File: rtl/fp_composer_if.sv
// Handshake bundle between the multiply datapath, the composer and the result consumer.
// master: the side that presents operands and accepts results; slave: the composer itself.
interface fp_composer_if #(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exponent;
  logic [MANT_W-1:0] in_mantissa;
  logic              in_special;
  logic [31:0]       in_special_value;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;

  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, in_special, in_special_value,
    output out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, in_special, in_special_value,
    input  out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp_composer.sv
// Back end of the FP multiply path: normalizes a raw sign/exponent/product
// mantissa one bit per cycle, rounds to nearest-even, saturates or flushes
// out-of-range results and packs an IEEE-754 single.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an operation (in_ready high once out of reset)
// S_NORM  | shifting the mantissa until its leading one sits at bit 46
// S_ROUND | round-to-nearest-even, range check, pack
// S_OUT   | result presented, held until the consumer takes it
module fp_composer #(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic clk,
  input  logic rst_n,
  fp_composer_if.slave bus
);

  // Exponent carried one bit wider than the input so shifts never wrap.
  localparam int IEXP_W = EXP_W + 1;
  localparam logic signed [IEXP_W-1:0] EXP_ONE = IEXP_W'(1);
  localparam logic signed [IEXP_W-1:0] EXP_MAX = IEXP_W'(255);
  localparam logic signed [IEXP_W-1:0] EXP_MIN = IEXP_W'(0);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic                      rdy_q, rdy_d;
  logic                      sign_q, sign_d;
  logic signed [IEXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0]         mant_q, mant_d;
  logic                      sticky_q, sticky_d;
  logic [31:0]               result_q, result_d;
  logic                      ovf_q, ovf_d;
  logic                      unf_q, unf_d;

  logic                      accept;
  logic signed [IEXP_W-1:0]  exp_in;
  logic [23:0]               keep;
  logic                      guard, st, up;
  logic [24:0]               sum;
  logic [22:0]               frac;
  logic signed [IEXP_W-1:0]  exp_rnd;

  assign accept = bus.in_valid & rdy_q & (state_q == S_IDLE);
  assign exp_in = $signed({bus.in_exponent[EXP_W-1], bus.in_exponent});

  assign bus.in_ready      = rdy_q;
  assign bus.out_valid     = (state_q == S_OUT);
  assign bus.out_result    = result_q;
  assign bus.out_overflow  = ovf_q;
  assign bus.out_underflow = unf_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and next datapath values, including the rounding arithmetic.
  always_comb begin
    state_d  = state_q;
    rdy_d    = rdy_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    keep    = mant_q[MANT_W-2 -: 24];
    guard   = mant_q[MANT_W-26];
    st      = (|mant_q[MANT_W-27:0]) | sticky_q;
    up      = guard & (st | keep[0]);
    sum     = {1'b0, keep} + {24'b0, up};
    frac    = sum[22:0];
    exp_rnd = exp_q;
    if (sum[24]) begin
      frac    = sum[23:1];
      exp_rnd = exp_q + EXP_ONE;
    end

    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          rdy_d = 1'b0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (bus.in_special) begin
            result_d = bus.in_special_value;
            state_d  = S_OUT;
          end else if (bus.in_mantissa == '0) begin
            result_d = {bus.in_sign, 31'b0};
            state_d  = S_OUT;
          end else begin
            sign_d   = bus.in_sign;
            exp_d    = exp_in;
            mant_d   = bus.in_mantissa;
            sticky_d = 1'b0;
            state_d  = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mant_q[MANT_W-1]) begin
          mant_d   = mant_q >> 1;
          sticky_d = sticky_q | mant_q[0];
          exp_d    = exp_q + EXP_ONE;
          state_d  = S_ROUND;
        end else if (!mant_q[MANT_W-2]) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_ONE;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (exp_rnd >= EXP_MAX) begin
          result_d = {sign_q, 8'hFF, 23'b0};
          ovf_d    = 1'b1;
        end else if (exp_rnd <= EXP_MIN) begin
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], frac};
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and handshake registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rdy_q    <= rdy_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_fp_composer.sv
// Directed bench for fp_composer: table of operations with hand-computed
// results and latencies, plus backpressure and mid-operation reset sequences.
module tb_fp_composer;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fp_composer_if #(.MANT_W(48), .EXP_W(10)) bus ();

  fp_composer #(.MANT_W(48), .EXP_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic        special;
    logic [31:0] sval;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({v.name, ".in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_sign          = v.sign;
    bus.in_exponent      = v.exp;
    bus.in_mantissa      = v.mant;
    bus.in_special       = v.special;
    bus.in_special_value = v.sval;
    bus.in_valid         = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid         = 1'b0;
    bus.in_sign          = 1'($urandom);
    bus.in_exponent      = 10'($urandom);
    bus.in_mantissa      = {16'($urandom), 32'($urandom)};
    bus.in_special       = 1'($urandom);
    bus.in_special_value = $urandom;
  endtask

  // Counts cycles from the accept edge (cycle 1) to out_valid seen high.
  task automatic wait_valid(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || lat > 80) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    start_op(v);
    wait_valid(lat);
    check({v.name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({v.name, ".latency"}, 32'(lat), 32'(v.lat));
    check({v.name, ".result"}, bus.out_result, v.res);
    check({v.name, ".overflow"}, 32'(bus.out_overflow), 32'(v.ovf));
    check({v.name, ".underflow"}, 32'(bus.out_underflow), 32'(v.unf));
    @(negedge clk);
    check({v.name, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({v.name, ".out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int   lat;
    int   stray;
    vec_t bp;

    vecs[0]  = '{"basic",       1'b0, 10'd128, 48'h600000000000, 1'b0, 32'h0, 32'h40400000, 1'b0, 1'b0, 3};
    vecs[1]  = '{"carry",       1'b0, 10'd129, 48'h900000000000, 1'b0, 32'h0, 32'h41100000, 1'b0, 1'b0, 3};
    vecs[2]  = '{"lshift2",     1'b0, 10'd130, 48'h100000000000, 1'b0, 32'h0, 32'h40000000, 1'b0, 1'b0, 5};
    vecs[3]  = '{"tie_odd",     1'b0, 10'd127, 48'h400000C00000, 1'b0, 32'h0, 32'h3F800002, 1'b0, 1'b0, 3};
    vecs[4]  = '{"tie_even",    1'b0, 10'd127, 48'h400000400000, 1'b0, 32'h0, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[5]  = '{"rnd_carry",   1'b0, 10'd127, 48'h7FFFFFC00000, 1'b0, 32'h0, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[6]  = '{"overflow",    1'b0, 10'd254, 48'h800000000000, 1'b0, 32'h0, 32'h7F800000, 1'b1, 1'b0, 3};
    vecs[7]  = '{"max_normal",  1'b0, 10'd254, 48'h400000000000, 1'b0, 32'h0, 32'h7F000000, 1'b0, 1'b0, 3};
    vecs[8]  = '{"underflow",   1'b1, 10'd1,   48'h200000000000, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b1, 4};
    vecs[9]  = '{"special_nan", 1'b0, 10'd5,   48'h123456789ABC, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[10] = '{"neg_zero",    1'b1, 10'd140, 48'h000000000000, 1'b0, 32'h0, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[11] = '{"sticky_rnd",  1'b0, 10'd127, 48'h800000800001, 1'b0, 32'h0, 32'h40000001, 1'b0, 1'b0, 3};
    vecs[12] = '{"lshift46",    1'b1, 10'd173, 48'h000000000001, 1'b0, 32'h0, 32'hBF800000, 1'b0, 1'b0, 49};
    vecs[13] = '{"neg_exp",     1'b0, 10'h3FB, 48'h000000000001, 1'b0, 32'h0, 32'h00000000, 1'b0, 1'b1, 49};

    rst_n                = 1'b0;
    bus.in_valid         = 1'b0;
    bus.in_sign          = 1'b0;
    bus.in_exponent      = '0;
    bus.in_mantissa      = '0;
    bus.in_special       = 1'b0;
    bus.in_special_value = '0;
    bus.out_ready        = 1'b1;

    #3;
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_result", bus.out_result, 32'd0);
    check("rst.flags", {30'd0, bus.out_overflow, bus.out_underflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_release", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("rst.in_ready_first_edge", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    bp = vecs[0];
    start_op(bp);
    wait_valid(lat);
    check("bp.latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid         = 1'b1;
      bus.in_special       = 1'b1;
      bus.in_special_value = 32'h12345678;
      @(negedge clk);
      check("bp.hold_result", bus.out_result, 32'h40400000);
      check("bp.hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.release_valid", 32'(bus.out_valid), 32'd0);
    check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) stray++;
    end
    check("bp.no_extra_transfer", 32'(stray), 32'd0);

    // Reset in the middle of a long normalization.
    start_op(vecs[12]);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.out_result", bus.out_result, 32'd0);
    check("midrst.flags", {30'd0, bus.out_overflow, bus.out_underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) stray++;
    end
    check("midrst.no_stale_output", 32'(stray), 32'd0);
    run_op(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
